// File: rtl/writeback_arbiter_rr_if.sv
// Bundle of the source-side request/ack signals and the WB-stage slot signals.
// Handshakes: a source is accepted on a cycle where src_valid[i] & src_ack[i]; the slot is consumed on wb_valid & wb_ready.
interface writeback_arbiter_rr_if #(
   parameter int NUM_SRC = 4,
   parameter int DATA_W  = 64,
   parameter int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
);
   logic [NUM_SRC-1:0]        src_valid;
   logic [NUM_SRC-1:0]        src_ack;
   logic [NUM_SRC*DATA_W-1:0] src_data;
   logic                      wb_valid;
   logic                      wb_ready;
   logic [DATA_W-1:0]         wb_data;
   logic [IDX_W-1:0]          wb_src;

   modport slave (
      input  src_valid, src_data, wb_ready,
      output src_ack, wb_valid, wb_data, wb_src
   );

   modport master (
      output src_valid, src_data, wb_ready,
      input  src_ack, wb_valid, wb_data, wb_src
   );
endinterface

// File: rtl/writeback_arbiter_rr.sv
// N-way writeback arbiter feeding one registered WB slot; round-robin or fixed priority.
// The slot output is a pure register, so wb_valid never depends combinationally on wb_ready.
module writeback_arbiter_rr #(
   parameter int NUM_SRC   = 4,
   parameter int DATA_W    = 64,
   parameter int FIXED_PRI = 0,
   localparam int IDX_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  flush_i,
   writeback_arbiter_rr_if.slave bus,
   output logic [IDX_W-1:0]      dbg_ptr_o
);

   logic [IDX_W-1:0]  ptr_q, ptr_d;
   logic [IDX_W-1:0]  sel, idx;
   logic              wb_valid_q, wb_valid_d;
   logic [DATA_W-1:0] wb_data_q, wb_data_d;
   logic [IDX_W-1:0]  wb_src_q, wb_src_d;
   logic [NUM_SRC-1:0] ack;
   logic              any_valid, can_acc, accept;

   // Scan in reverse search order so the last hit is the first valid index at/after the start point.
   always_comb begin
      sel = '0;
      idx = '0;
      for (int k = NUM_SRC - 1; k >= 0; k--) begin
         if (FIXED_PRI != 0) begin
            idx = IDX_W'(k);
         end else begin
            idx = IDX_W'((int'(ptr_q) + k) % NUM_SRC);
         end
         if (bus.src_valid[idx]) begin
            sel = idx;
         end
      end
   end

   assign any_valid = |bus.src_valid;
   assign can_acc   = !wb_valid_q | bus.wb_ready;
   assign accept    = any_valid & can_acc & !flush_i & !rst_i;

   always_comb begin
      ack = '0;
      if (accept) begin
         ack[sel] = 1'b1;
      end
   end

   always_comb begin
      wb_valid_d = wb_valid_q;
      wb_data_d  = wb_data_q;
      wb_src_d   = wb_src_q;
      ptr_d      = ptr_q;
      if (flush_i) begin
         wb_valid_d = 1'b0;
      end else if (accept) begin
         wb_valid_d = 1'b1;
         wb_data_d  = bus.src_data[int'(sel)*DATA_W +: DATA_W];
         wb_src_d   = sel;
         if (FIXED_PRI == 0) begin
            ptr_d = (sel == IDX_W'(NUM_SRC - 1)) ? '0 : sel + IDX_W'(1);
         end
      end else if (bus.wb_ready) begin
         wb_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wb_valid_q <= 1'b0;
         wb_data_q  <= '0;
         wb_src_q   <= '0;
         ptr_q      <= '0;
      end else begin
         wb_valid_q <= wb_valid_d;
         wb_data_q  <= wb_data_d;
         wb_src_q   <= wb_src_d;
         ptr_q      <= ptr_d;
      end
   end

   assign bus.src_ack  = ack;
   assign bus.wb_valid = wb_valid_q;
   assign bus.wb_data  = wb_data_q;
   assign bus.wb_src   = wb_src_q;
   assign dbg_ptr_o    = ptr_q;

   a_ack_onehot: assert property (@(posedge clk_i) $onehot0(bus.src_ack));
   a_ack_needs_valid: assert property (@(posedge clk_i) (bus.src_ack & ~bus.src_valid) == '0);
   a_hold_stable: assert property (@(posedge clk_i) disable iff (rst_i)
      (bus.wb_valid & !bus.wb_ready) |=> $stable(bus.wb_data));

endmodule

// File: tb/tb_writeback_arbiter_rr.sv
// Bench for writeback_arbiter_rr: a round-robin and a fixed-priority instance share one stimulus stream
// and are checked against a queue-based reference model of the WB slot.
module tb_writeback_arbiter_rr;
   localparam int N  = 4;
   localparam int W  = 16;
   localparam int IW = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic flush = 1'b0;
   logic [IW-1:0] dbg_ptr_rr, dbg_ptr_fp;

   int checks = 0;
   int errors = 0;

   writeback_arbiter_rr_if #(.NUM_SRC(N), .DATA_W(W), .IDX_W(IW)) bus_rr ();
   writeback_arbiter_rr_if #(.NUM_SRC(N), .DATA_W(W), .IDX_W(IW)) bus_fp ();

   writeback_arbiter_rr #(.NUM_SRC(N), .DATA_W(W), .FIXED_PRI(0)) dut_rr (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .bus(bus_rr.slave), .dbg_ptr_o(dbg_ptr_rr)
   );
   writeback_arbiter_rr #(.NUM_SRC(N), .DATA_W(W), .FIXED_PRI(1)) dut_fp (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .bus(bus_fp.slave), .dbg_ptr_o(dbg_ptr_fp)
   );

   always #5 clk = ~clk;

   // reference model: pending writebacks as queues, plus the round-robin start index
   int            m_ptr = 0;
   logic [W-1:0]  exp_q_rr[$];
   logic [W-1:0]  exp_q_fp[$];
   int            src_q_rr[$];
   int            src_q_fp[$];
   logic [N-1:0]  exp_ack_rr, exp_ack_fp;
   int            pick_rr, pick_fp;
   bit            acc_rr, acc_fp;
   bit            cur_rdy, cur_fl, cur_rs;
   logic [W-1:0]  cur_data[N];

   function automatic int pick(input logic [N-1:0] v, input int start, input bit fixed);
      for (int k = 0; k < N; k++) begin
         int i;
         i = fixed ? k : (start + k) % N;
         if (v[i]) return i;
      end
      return -1;
   endfunction

   task automatic drive(input logic [N-1:0] v, input bit rdy, input bit fl, input bit rs);
      cur_rdy = rdy;
      cur_fl  = fl;
      cur_rs  = rs;
      for (int i = 0; i < N; i++) begin
         cur_data[i] = W'($urandom);
         bus_rr.src_data[i*W +: W] = cur_data[i];
         bus_fp.src_data[i*W +: W] = cur_data[i];
      end
      rst = rs;
      flush = fl;
      bus_rr.src_valid = v;
      bus_fp.src_valid = v;
      bus_rr.wb_ready = rdy;
      bus_fp.wb_ready = rdy;
      pick_rr = pick(v, m_ptr, 1'b0);
      pick_fp = pick(v, 0, 1'b1);
      acc_rr = !rs && !fl && pick_rr >= 0 && (exp_q_rr.size() == 0 || rdy);
      acc_fp = !rs && !fl && pick_fp >= 0 && (exp_q_fp.size() == 0 || rdy);
      exp_ack_rr = acc_rr ? (N'(1) << pick_rr) : '0;
      exp_ack_fp = acc_fp ? (N'(1) << pick_fp) : '0;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      if (cur_rs) begin
         exp_q_rr.delete(); src_q_rr.delete();
         exp_q_fp.delete(); src_q_fp.delete();
         m_ptr = 0;
      end else if (cur_fl) begin
         exp_q_rr.delete(); src_q_rr.delete();
         exp_q_fp.delete(); src_q_fp.delete();
      end else begin
         if (exp_q_rr.size() != 0 && cur_rdy) begin
            void'(exp_q_rr.pop_front()); void'(src_q_rr.pop_front());
         end
         if (exp_q_fp.size() != 0 && cur_rdy) begin
            void'(exp_q_fp.pop_front()); void'(src_q_fp.pop_front());
         end
         if (acc_rr) begin
            exp_q_rr.push_back(cur_data[pick_rr]); src_q_rr.push_back(pick_rr);
            m_ptr = (pick_rr + 1) % N;
         end
         if (acc_fp) begin
            exp_q_fp.push_back(cur_data[pick_fp]); src_q_fp.push_back(pick_fp);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      drive(4'b1111, 1'b1, 1'b0, 1'b1);
      checks++;
      if (bus_rr.src_ack !== 4'b0000 || bus_fp.src_ack !== 4'b0000) begin
         errors++; $display("FAIL reset_ack: got rr=%b fp=%b want 0000", bus_rr.src_ack, bus_fp.src_ack);
      end
      tick();
      drive(4'b0000, 1'b0, 1'b0, 1'b0);
      checks++;
      if (bus_rr.wb_valid !== 1'b0 || bus_fp.wb_valid !== 1'b0) begin
         errors++; $display("FAIL reset_valid: got rr=%b fp=%b want 0", bus_rr.wb_valid, bus_fp.wb_valid);
      end
      checks++;
      if (bus_rr.wb_data !== 16'h0 || bus_rr.wb_src !== 2'd0) begin
         errors++; $display("FAIL reset_data: got data=%h src=%0d want 0/0", bus_rr.wb_data, bus_rr.wb_src);
      end
      checks++;
      if (dbg_ptr_rr !== 2'd0 || dbg_ptr_fp !== 2'd0) begin
         errors++; $display("FAIL reset_ptr: got rr=%0d fp=%0d want 0", dbg_ptr_rr, dbg_ptr_fp);
      end
      tick();
   endtask

   task automatic test_rr_fairness();
      for (int k = 0; k <= 8; k++) begin
         drive((k < 8) ? 4'b1111 : 4'b0000, 1'b1, 1'b0, 1'b0);
         if (k > 0) begin
            checks++;
            if (bus_rr.wb_valid !== 1'b1 || bus_rr.wb_src !== 2'((k - 1) % 4) || bus_rr.wb_data !== exp_q_rr[0]) begin
               errors++; $display("FAIL fair_out[%0d]: got v=%b src=%0d data=%h want 1/%0d/%h",
                  k, bus_rr.wb_valid, bus_rr.wb_src, bus_rr.wb_data, (k - 1) % 4, exp_q_rr[0]);
            end
         end
         if (k < 8) begin
            checks++;
            if (bus_rr.src_ack !== (4'b0001 << (k % 4))) begin
               errors++; $display("FAIL fair_ack[%0d]: got %b want %b", k, bus_rr.src_ack, 4'b0001 << (k % 4));
            end
            checks++;
            if (bus_fp.src_ack !== 4'b0001) begin
               errors++; $display("FAIL fair_fp_ack[%0d]: got %b want 0001", k, bus_fp.src_ack);
            end
         end
         tick();
      end
   endtask

   task automatic test_pointer_skip();
      drive(4'b0001, 1'b1, 1'b0, 1'b0);
      tick();
      checks++;
      if (dbg_ptr_rr !== 2'd1) begin
         errors++; $display("FAIL skip_setup_ptr: got %0d want 1", dbg_ptr_rr);
      end
      drive(4'b0101, 1'b1, 1'b0, 1'b0);
      checks++;
      if (bus_rr.src_ack !== 4'b0100) begin
         errors++; $display("FAIL skip_ack1: got %b want 0100", bus_rr.src_ack);
      end
      tick();
      drive(4'b0001, 1'b1, 1'b0, 1'b0);
      checks++;
      if (bus_rr.src_ack !== 4'b0001 || bus_rr.wb_src !== 2'd2) begin
         errors++; $display("FAIL skip_ack2: got ack=%b src=%0d want 0001/2", bus_rr.src_ack, bus_rr.wb_src);
      end
      tick();
      drive(4'b0000, 1'b1, 1'b0, 1'b0);
      checks++;
      if (bus_rr.wb_src !== 2'd0 || dbg_ptr_rr !== 2'd1) begin
         errors++; $display("FAIL skip_end: got src=%0d ptr=%0d want 0/1", bus_rr.wb_src, dbg_ptr_rr);
      end
      tick();
   endtask

   task automatic test_backpressure();
      logic [W-1:0] held;
      drive(4'b1111, 1'b1, 1'b0, 1'b0);
      held = cur_data[1];
      tick();
      for (int k = 0; k < 3; k++) begin
         drive(4'b1111, 1'b0, 1'b0, 1'b0);
         checks++;
         if (bus_rr.src_ack !== 4'b0000 || bus_fp.src_ack !== 4'b0000) begin
            errors++; $display("FAIL bp_ack[%0d]: got rr=%b fp=%b want 0000", k, bus_rr.src_ack, bus_fp.src_ack);
         end
         checks++;
         if (bus_rr.wb_valid !== 1'b1 || bus_rr.wb_data !== held || bus_rr.wb_src !== 2'd1) begin
            errors++; $display("FAIL bp_hold[%0d]: got v=%b data=%h src=%0d want 1/%h/1",
               k, bus_rr.wb_valid, bus_rr.wb_data, bus_rr.wb_src, held);
         end
         tick();
      end
      drive(4'b1111, 1'b1, 1'b0, 1'b0);
      checks++;
      if (bus_rr.src_ack !== 4'b0100) begin
         errors++; $display("FAIL bp_release_ack: got %b want 0100", bus_rr.src_ack);
      end
      tick();
      drive(4'b0000, 1'b1, 1'b0, 1'b0);
      checks++;
      if (bus_rr.wb_src !== 2'd2 || bus_rr.wb_data !== exp_q_rr[0]) begin
         errors++; $display("FAIL bp_release_out: got src=%0d data=%h want 2/%h", bus_rr.wb_src, bus_rr.wb_data, exp_q_rr[0]);
      end
      tick();
   endtask

   task automatic test_fixed_priority();
      for (int k = 0; k < 5; k++) begin
         drive(4'b1010, 1'b1, 1'b0, 1'b0);
         checks++;
         if (bus_fp.src_ack !== 4'b0010) begin
            errors++; $display("FAIL fp_ack[%0d]: got %b want 0010", k, bus_fp.src_ack);
         end
         if (k > 0) begin
            checks++;
            if (bus_fp.wb_src !== 2'd1 || bus_fp.wb_valid !== 1'b1) begin
               errors++; $display("FAIL fp_src[%0d]: got v=%b src=%0d want 1/1", k, bus_fp.wb_valid, bus_fp.wb_src);
            end
         end
         tick();
      end
      drive(4'b0000, 1'b1, 1'b0, 1'b0);
      tick();
   endtask

   task automatic test_flush();
      drive(4'b0001, 1'b1, 1'b0, 1'b0);
      tick();
      drive(4'b0100, 1'b1, 1'b1, 1'b0);
      checks++;
      if (bus_rr.src_ack !== 4'b0000 || bus_fp.src_ack !== 4'b0000 || bus_rr.wb_valid !== 1'b1) begin
         errors++; $display("FAIL flush_cycle: got rr=%b fp=%b v=%b want 0000/0000/1",
            bus_rr.src_ack, bus_fp.src_ack, bus_rr.wb_valid);
      end
      tick();
      drive(4'b0100, 1'b1, 1'b0, 1'b0);
      checks++;
      if (bus_rr.wb_valid !== 1'b0 || bus_fp.wb_valid !== 1'b0) begin
         errors++; $display("FAIL flush_valid: got rr=%b fp=%b want 0", bus_rr.wb_valid, bus_fp.wb_valid);
      end
      checks++;
      if (bus_rr.src_ack !== 4'b0100 || bus_fp.src_ack !== 4'b0100) begin
         errors++; $display("FAIL flush_regrant: got rr=%b fp=%b want 0100", bus_rr.src_ack, bus_fp.src_ack);
      end
      tick();
      drive(4'b0000, 1'b1, 1'b0, 1'b0);
      checks++;
      if (bus_rr.wb_src !== 2'd2 || bus_rr.wb_valid !== 1'b1) begin
         errors++; $display("FAIL flush_after: got v=%b src=%0d want 1/2", bus_rr.wb_valid, bus_rr.wb_src);
      end
      tick();
   endtask

   task automatic test_reset_midstream();
      for (int k = 0; k < 3; k++) begin
         drive(4'b1111, 1'b1, 1'b0, 1'b0);
         tick();
      end
      drive(4'b1111, 1'b1, 1'b0, 1'b1);
      checks++;
      if (bus_rr.src_ack !== 4'b0000 || bus_fp.src_ack !== 4'b0000) begin
         errors++; $display("FAIL midrst_ack: got rr=%b fp=%b want 0000", bus_rr.src_ack, bus_fp.src_ack);
      end
      tick();
      drive(4'b0110, 1'b1, 1'b0, 1'b0);
      checks++;
      if (bus_rr.wb_valid !== 1'b0 || dbg_ptr_rr !== 2'd0) begin
         errors++; $display("FAIL midrst_state: got v=%b ptr=%0d want 0/0", bus_rr.wb_valid, dbg_ptr_rr);
      end
      checks++;
      if (bus_rr.src_ack !== 4'b0010) begin
         errors++; $display("FAIL midrst_grant: got %b want 0010", bus_rr.src_ack);
      end
      tick();
      drive(4'b0000, 1'b1, 1'b0, 1'b0);
      checks++;
      if (bus_rr.wb_src !== 2'd1) begin
         errors++; $display("FAIL midrst_src: got %0d want 1", bus_rr.wb_src);
      end
      tick();
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         drive(N'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
               ($urandom_range(0, 39) == 0));
         checks++;
         if (bus_rr.src_ack !== exp_ack_rr || bus_fp.src_ack !== exp_ack_fp) begin
            errors++; $display("FAIL rand_ack[%0d]: got rr=%b fp=%b want rr=%b fp=%b",
               k, bus_rr.src_ack, bus_fp.src_ack, exp_ack_rr, exp_ack_fp);
         end
         checks++;
         if (bus_rr.wb_valid !== (exp_q_rr.size() != 0) || bus_fp.wb_valid !== (exp_q_fp.size() != 0)) begin
            errors++; $display("FAIL rand_valid[%0d]: got rr=%b fp=%b want rr=%0d fp=%0d",
               k, bus_rr.wb_valid, bus_fp.wb_valid, exp_q_rr.size(), exp_q_fp.size());
         end
         if (exp_q_rr.size() != 0) begin
            checks++;
            if (bus_rr.wb_data !== exp_q_rr[0] || bus_rr.wb_src !== 2'(src_q_rr[0])) begin
               errors++; $display("FAIL rand_rr_out[%0d]: got %h/%0d want %h/%0d",
                  k, bus_rr.wb_data, bus_rr.wb_src, exp_q_rr[0], src_q_rr[0]);
            end
         end
         if (exp_q_fp.size() != 0) begin
            checks++;
            if (bus_fp.wb_data !== exp_q_fp[0] || bus_fp.wb_src !== 2'(src_q_fp[0])) begin
               errors++; $display("FAIL rand_fp_out[%0d]: got %h/%0d want %h/%0d",
                  k, bus_fp.wb_data, bus_fp.wb_src, exp_q_fp[0], src_q_fp[0]);
            end
         end
         checks++;
         if (dbg_ptr_rr !== 2'(m_ptr)) begin
            errors++; $display("FAIL rand_ptr[%0d]: got %0d want %0d", k, dbg_ptr_rr, m_ptr);
         end
         tick();
      end
   endtask

   initial begin
      bus_rr.src_valid = '0; bus_fp.src_valid = '0;
      bus_rr.src_data  = '0; bus_fp.src_data  = '0;
      bus_rr.wb_ready  = 1'b0; bus_fp.wb_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_rr_fairness();
      test_pointer_skip();
      test_backpressure();
      test_fixed_priority();
      test_flush();
      test_reset_midstream();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
